// File: rtl/urna_cedula_tx.sv
// Ballot transmitter for the voting urn. It sends four BCD digits, plus a confirm digit when needed,
// as Valid strobes, then closes the ballot with a Finish strobe. Every urn-facing output is a flop.
module urna_cedula_tx #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Code,
  input  logic        Status,
  output logic [3:0]  Digit,
  output logic        Valid,
  output logic        Finish,
  output logic        Busy,
  output logic        Done,
  output logic        Voted,
  output logic        Timeout
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_SETUP        = 3'd1,
    S_STROBE       = 3'd2,
    S_WAIT_ACK     = 3'd3,
    S_CLOSE_SETUP  = 3'd4,
    S_CLOSE_STROBE = 3'd5,
    S_DONE         = 3'd6
  } state_e;

  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  sync_q, sync_d;
  logic [3:0]  digit_q, digit_d;
  logic        valid_q, valid_d;
  logic        finish_q, finish_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        voted_q, voted_d;
  logic        timeout_q, timeout_d;
  logic        st_s;

  function automatic logic [3:0] pick_nibble(input logic [15:0] code, input logic [2:0] idx);
    case (idx)
      3'd0:    pick_nibble = code[15:12];
      3'd1:    pick_nibble = code[11:8];
      3'd2:    pick_nibble = code[7:4];
      3'd3:    pick_nibble = code[3:0];
      default: pick_nibble = 4'hF;
    endcase
  endfunction

  assign st_s = sync_q[1];

  // Next-state, ballot bookkeeping and the per-state cycle counter
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    idx_d     = idx_q;
    voted_d   = voted_q;
    timeout_d = timeout_q;
    sync_d    = {sync_q[0], Status};
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_SETUP;
          code_d    = Code;
          idx_d     = 3'd0;
          voted_d   = 1'b0;
          timeout_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        // An acknowledge after any data strobe ends the ballot before the pending strobe
        if ((idx_q != 3'd0) && st_s) begin
          voted_d = 1'b1;
          state_d = S_CLOSE_SETUP;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_STROBE;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          if (idx_q == 3'd4) begin
            state_d = S_WAIT_ACK;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SETUP;
          end
        end else begin
          state_d = S_STROBE;
        end
      end
      S_WAIT_ACK: begin
        if (st_s) begin
          voted_d = 1'b1;
          state_d = S_CLOSE_SETUP;
        end else if (cnt_q == ACK_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CLOSE_SETUP;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_CLOSE_SETUP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_CLOSE_STROBE;
        end else begin
          state_d = S_CLOSE_SETUP;
        end
      end
      S_CLOSE_STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLOSE_STROBE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Urn-facing outputs decoded from the current state, then registered so they change only on edges
  always_comb begin
    digit_d  = 4'h0;
    valid_d  = 1'b0;
    finish_d = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE:         busy_d = 1'b0;
      S_SETUP:        digit_d = pick_nibble(code_q, idx_q);
      S_WAIT_ACK:     digit_d = pick_nibble(code_q, idx_q);
      S_STROBE: begin
        digit_d = pick_nibble(code_q, idx_q);
        valid_d = 1'b1;
      end
      S_CLOSE_SETUP:  finish_d = 1'b1;
      S_CLOSE_STROBE: begin
        finish_d = 1'b1;
        valid_d  = 1'b1;
      end
      S_DONE:         done_d = 1'b1;
      default:        busy_d = 1'b0;
    endcase
  end

  // State, synchronizer and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      code_q    <= 16'h0000;
      idx_q     <= 3'd0;
      cnt_q     <= 8'd0;
      sync_q    <= 2'b00;
      digit_q   <= 4'h0;
      valid_q   <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      voted_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      voted_q   <= voted_d;
      timeout_q <= timeout_d;
    end
  end

  assign Digit   = digit_q;
  assign Valid   = valid_q;
  assign Finish  = finish_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Voted   = voted_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_urna_cedula_tx.sv
// Directed bench for urna_cedula_tx with a behavioural urn that knows candidates 3494 and 3504.
module tb_urna_cedula_tx;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Code  = 16'h0000;
  logic        Status;
  logic [3:0]  Digit;
  logic        Valid, Finish, Busy, Done, Voted, Timeout;

  logic urn_rst  = 1'b0;
  logic urn_mute = 1'b0;
  logic urn_st;
  logic null_st;
  logic [3:0] seen [0:11];
  logic       fin_at [0:11];
  int total, data_n, closes, nulls, votes, ubuf, un;
  int done_cnt, wait_cyc;
  int checks = 0;
  int errors = 0;

  assign Status = urn_st & ~urn_mute;

  always #5 Clock = ~Clock;

  urna_cedula_tx #(.PULSE_CYCLES(4), .GAP_CYCLES(4), .ACK_TIMEOUT(20)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Code(Code), .Status(Status),
    .Digit(Digit), .Valid(Valid), .Finish(Finish), .Busy(Busy), .Done(Done),
    .Voted(Voted), .Timeout(Timeout)
  );

  function automatic bit prefix_ok(input int b, input int n);
    int sh;
    sh = 4 * (4 - n);
    prefix_ok = ((32'h3494 >> sh) == b) || ((32'h3504 >> sh) == b);
  endfunction

  // Urn: acts on Valid rises; an unknown prefix sends it null and the next strobe acknowledges
  always begin
    @(posedge Valid or posedge urn_rst);
    if (urn_rst) begin
      urn_st = 1'b0; null_st = 1'b0;
      total = 0; data_n = 0; closes = 0; nulls = 0; votes = 0; ubuf = 0; un = 0;
      for (int i = 0; i < 12; i++) begin seen[i] = 4'h0; fin_at[i] = 1'b0; end
    end else begin
      if (total < 12) begin seen[total] = Digit; fin_at[total] = Finish; end
      total++;
      if (Finish) begin
        closes++; urn_st = 1'b0; null_st = 1'b0; ubuf = 0; un = 0;
      end else begin
        data_n++;
        if (null_st || Digit == 4'hF) begin
          nulls++; urn_st = 1'b1;
        end else begin
          ubuf = ubuf * 16 + int'(Digit);
          un++;
          if (!prefix_ok(ubuf, un)) null_st = 1'b1;
          else if (un == 4) begin votes++; urn_st = 1'b1; end
        end
      end
    end
  end

  always begin
    @(negedge Clock or posedge urn_rst);
    if (urn_rst) begin
      done_cnt = 0; wait_cyc = 0;
    end else begin
      if (Done) done_cnt++;
      if (Busy && !Valid && !Finish && data_n == 5 && closes == 0) wait_cyc++;
    end
  end

  task automatic urn_clear;
    urn_rst = 1'b1; #1; urn_rst = 1'b0;
  endtask

  task automatic start_ballot(input logic [15:0] c);
    @(negedge Clock); Code = c; Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      if (Done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clock);
    checks++;
    if ({Digit, Valid, Finish, Busy, Done, Voted, Timeout} !== 10'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected 000", {Digit, Valid, Finish, Busy, Done, Voted, Timeout});
    end
    @(negedge Clock); Reset = 1'b1;
    urn_clear();
  endtask

  task automatic test_valid_vote;
    int cyc;
    bit ok;
    urn_clear();
    @(negedge Clock); Code = 16'h3494; Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock); #1; cyc++;
      if (cyc == 1) begin
        checks++;
        if ({Busy, Digit, Valid} !== 6'b1_0011_0) begin
          errors++; $display("FAIL first_cycle: got %b expected 100110", {Busy, Digit, Valid});
        end
      end
      if (Valid) break;
    end
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL first_rise_latency: got %0d expected 5", cyc); end
    wait_done(ok);
    @(negedge Clock);
    checks++;
    if (!ok) begin errors++; $display("FAIL vote_done_seen: got 0 expected 1"); end
    checks++;
    if (total != 5) begin errors++; $display("FAIL vote_rises: got %0d expected 5", total); end
    checks++;
    if ({seen[0], seen[1], seen[2], seen[3]} !== 16'h3494) begin
      errors++; $display("FAIL vote_digits: got %h expected 3494", {seen[0], seen[1], seen[2], seen[3]});
    end
    checks++;
    if ({fin_at[0], fin_at[1], fin_at[2], fin_at[3], fin_at[4]} !== 5'b00001) begin
      errors++; $display("FAIL vote_finish_pattern: got %b expected 00001", {fin_at[0], fin_at[1], fin_at[2], fin_at[3], fin_at[4]});
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL vote_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if ({Voted, Timeout, Busy} !== 3'b100) begin
      errors++; $display("FAIL vote_flags: got %b expected 100", {Voted, Timeout, Busy});
    end
    checks++;
    if (nulls != 0 || votes != 1) begin errors++; $display("FAIL vote_urn_tally: got %0d/%0d expected 0/1", nulls, votes); end
  endtask

  task automatic test_null_confirm;
    bit ok;
    urn_clear();
    start_ballot(16'h3491);
    wait_done(ok);
    @(negedge Clock);
    checks++;
    if (!ok || total != 6) begin errors++; $display("FAIL confirm_rises: got %0d expected 6", total); end
    checks++;
    if (seen[4] !== 4'hF || fin_at[4] !== 1'b0 || fin_at[5] !== 1'b1) begin
      errors++; $display("FAIL confirm_strobe: got %h/%b/%b expected f/0/1", seen[4], fin_at[4], fin_at[5]);
    end
    checks++;
    if (nulls != 1 || {Voted, Timeout} !== 2'b10) begin
      errors++; $display("FAIL confirm_result: got nulls %0d flags %b expected 1 10", nulls, {Voted, Timeout});
    end
  endtask

  task automatic test_early_null;
    bit ok;
    urn_clear();
    start_ballot(16'h1000);
    wait_done(ok);
    @(negedge Clock);
    checks++;
    if (!ok || total != 3 || data_n != 2) begin
      errors++; $display("FAIL early_null_rises: got %0d/%0d expected 3/2", total, data_n);
    end
    checks++;
    if ({seen[0], seen[1]} !== 8'h10 || fin_at[2] !== 1'b1) begin
      errors++; $display("FAIL early_null_digits: got %h fin %b expected 10 fin 1", {seen[0], seen[1]}, fin_at[2]);
    end
    checks++;
    if (nulls != 1 || Voted !== 1'b1) begin
      errors++; $display("FAIL early_null_result: got nulls %0d voted %b expected 1 1", nulls, Voted);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    urn_clear();
    urn_mute = 1'b1;
    start_ballot(16'h3494);
    wait_done(ok);
    @(negedge Clock);
    urn_mute = 1'b0;
    checks++;
    if (!ok || data_n != 5 || closes != 1) begin
      errors++; $display("FAIL timeout_strobes: got %0d data %0d close expected 5 1", data_n, closes);
    end
    checks++;
    if (wait_cyc != 20) begin errors++; $display("FAIL timeout_wait_cycles: got %0d expected 20", wait_cyc); end
    checks++;
    if ({Timeout, Voted} !== 2'b10 || done_cnt != 1) begin
      errors++; $display("FAIL timeout_flags: got %b done %0d expected 10 done 1", {Timeout, Voted}, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit hit;
    urn_clear();
    start_ballot(16'h3504);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Valid && data_n == 2) begin hit = 1'b1; break; end
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (!hit || {Valid, Finish, Busy, Digit} !== 7'h00) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 00", {Valid, Finish, Busy, Digit});
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (20) @(negedge Clock);
    checks++;
    if (closes != 0 || total != 2) begin
      errors++; $display("FAIL reset_mid_no_close: got %0d rises %0d closes expected 2 0", total, closes);
    end
    urn_clear();
    start_ballot(16'h3504);
    wait_done(ok);
    @(negedge Clock);
    checks++;
    if (!ok || total != 5 || {seen[0], seen[1], seen[2], seen[3]} !== 16'h3504 || Voted !== 1'b1) begin
      errors++; $display("FAIL reset_recover: got rises %0d digits %h voted %b expected 5 3504 1", total, {seen[0], seen[1], seen[2], seen[3]}, Voted);
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    urn_clear();
    start_ballot(16'h3494);
    repeat (10) @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(ok);
    repeat (10) @(negedge Clock);
    checks++;
    if (!ok || done_cnt != 1 || total != 5 || Busy !== 1'b0) begin
      errors++; $display("FAIL start_ignored: got done %0d rises %0d busy %b expected 1 5 0", done_cnt, total, Busy);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    urn_clear();
    @(negedge Clock); Code = 16'h3494; Start = 1'b1;
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_done: got 0 expected 1"); end
    @(negedge Clock);
    checks++;
    if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 00", {Busy, Done}); end
    @(negedge Clock);
    checks++;
    if ({Busy, Digit, Valid} !== 6'b1_0011_0) begin
      errors++; $display("FAIL b2b_restart: got %b expected 100110", {Busy, Digit, Valid});
    end
    Start = 1'b0;
    wait_done(ok);
    @(negedge Clock);
    checks++;
    if (!ok || done_cnt != 2 || votes != 2 || total != 10) begin
      errors++; $display("FAIL b2b_totals: got done %0d votes %0d rises %0d expected 2 2 10", done_cnt, votes, total);
    end
  endtask

  initial begin
    test_reset();
    test_valid_vote();
    test_null_confirm();
    test_early_null();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
